// File: rtl/branch_predictor_bht_pkg.sv
// ---------------------------------------------------------------------------
// branch_predictor_bht_pkg
// Shared definitions for the branch target buffer: next-PC select encodings
// and saturating-counter constants derived from the counter width.
// ---------------------------------------------------------------------------
package branch_predictor_bht_pkg;

  // Next-PC select driven to the fetch PC mux.
  typedef enum logic [1:0] {
    MUXPC_SEQ      = 2'd0,  // PC+4
    MUXPC_PRED     = 2'd1,  // predicted target from the table
    MUXPC_FALLTHRU = 2'd2,  // id_pc+4, recovery from a wrong taken guess
    MUXPC_TARGET   = 2'd3   // id_target, recovery from a wrong not-taken guess
  } muxpc_e;

  // Saturation ceiling of a cnt_w-bit counter.
  function automatic int cnt_max(input int cnt_w);
    return (1 << cnt_w) - 1;
  endfunction

  // Weakest "taken" value: MSB set, all lower bits clear.
  function automatic int cnt_weak_taken(input int cnt_w);
    return 1 << (cnt_w - 1);
  endfunction

  // Strongest value that still predicts not-taken (0 for a 1-bit counter).
  function automatic int cnt_weak_nt(input int cnt_w);
    return (1 << (cnt_w - 1)) - 1;
  endfunction

endpackage

// File: rtl/branch_predictor_bht_if.sv
// ---------------------------------------------------------------------------
// branch_predictor_bht_if
// Pipeline-side bundle of the predictor.
//   IF side : if_pc (in), if_hit / if_taken / if_target (out)
//   ID side : id_branch, id_equal, id_pc, id_target, id_pred_taken, id_stall (in)
//   Control : flush, muxpc (out)
//   Stats   : branch_count, mispredict_count (out)
// The slave modport is the predictor; master is the pipeline driving it.
// ---------------------------------------------------------------------------
interface branch_predictor_bht_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] if_pc;
  logic              if_hit;
  logic              if_taken;
  logic [ADDR_W-1:0] if_target;

  logic              id_branch;
  logic              id_equal;
  logic [ADDR_W-1:0] id_pc;
  logic [ADDR_W-1:0] id_target;
  logic              id_pred_taken;
  logic              id_stall;

  logic              flush;
  logic [1:0]        muxpc;
  logic [31:0]       branch_count;
  logic [31:0]       mispredict_count;

  modport master (
    output if_pc, id_branch, id_equal, id_pc, id_target, id_pred_taken, id_stall,
    input  if_hit, if_taken, if_target, flush, muxpc, branch_count, mispredict_count
  );

  modport slave (
    input  if_pc, id_branch, id_equal, id_pc, id_target, id_pred_taken, id_stall,
    output if_hit, if_taken, if_target, flush, muxpc, branch_count, mispredict_count
  );
endinterface

// File: rtl/branch_predictor_bht_entry_array.sv
// ---------------------------------------------------------------------------
// bht_entry_array
// Register-based table of 2^IDX_W predictor entries {valid, tag, target,
// counter}. One combinational read port (fetch lookup) and one update port.
// The update port is read-modify-write: it compares the stored tag itself and
// either trains the counter (hit) or allocates a fresh entry (miss), so the
// top never needs a second read port.
// Ports:
//   clk, rst            clock, async active-high clear of the whole table
//   i_rd_idx            lookup index
//   o_rd_valid/tag/target/counter   raw entry at i_rd_idx
//   i_wr_en             apply an update at the next clock edge
//   i_wr_idx/tag/target index, tag and target of the resolving branch
//   i_wr_taken          resolved direction
// ---------------------------------------------------------------------------
module bht_entry_array
  import branch_predictor_bht_pkg::*;
#(
  parameter int IDX_W  = 6,
  parameter int TAG_W  = 8,
  parameter int CNT_W  = 2,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  i_rd_idx,
  output logic              o_rd_valid,
  output logic [TAG_W-1:0]  o_rd_tag,
  output logic [ADDR_W-1:0] o_rd_target,
  output logic [CNT_W-1:0]  o_rd_counter,
  input  logic              i_wr_en,
  input  logic [IDX_W-1:0]  i_wr_idx,
  input  logic [TAG_W-1:0]  i_wr_tag,
  input  logic [ADDR_W-1:0] i_wr_target,
  input  logic              i_wr_taken
);

  localparam int DEPTH = 1 << IDX_W;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));
  localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(cnt_weak_taken(CNT_W));
  localparam logic [CNT_W-1:0] CNT_WNT = CNT_W'(cnt_weak_nt(CNT_W));
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [ADDR_W-1:0] target;
    logic [CNT_W-1:0]  counter;
  } entry_t;

  localparam entry_t ENTRY_RESET = '{valid: 1'b0, tag: '0, target: '0, counter: CNT_WNT};

  entry_t r_mem [DEPTH];
  entry_t w_rd;
  entry_t w_cur;
  entry_t w_next;

  assign w_rd         = r_mem[i_rd_idx];
  assign o_rd_valid   = w_rd.valid;
  assign o_rd_tag     = w_rd.tag;
  assign o_rd_target  = w_rd.target;
  assign o_rd_counter = w_rd.counter;

  always_comb begin
    w_cur          = r_mem[i_wr_idx];
    w_next         = w_cur;
    w_next.valid   = 1'b1;
    w_next.tag     = i_wr_tag;
    w_next.target  = i_wr_target;
    if (w_cur.valid && (w_cur.tag == i_wr_tag)) begin
      if (i_wr_taken) begin
        if (w_cur.counter != CNT_MAX) w_next.counter = w_cur.counter + CNT_ONE;
      end else begin
        if (w_cur.counter != '0) w_next.counter = w_cur.counter - CNT_ONE;
      end
    end else begin
      // Miss or alias: the old occupant is simply overwritten.
      w_next.counter = i_wr_taken ? CNT_WT : CNT_WNT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= ENTRY_RESET;
    end else if (i_wr_en) begin
      r_mem[i_wr_idx] <= w_next;
    end
  end

endmodule

// File: rtl/branch_predictor_bht.sv
// ---------------------------------------------------------------------------
// branch_predictor_bht
// Tagged branch target buffer with CNT_W-bit saturating direction counters.
// Fetch looks up if_pc combinationally; decode resolves conditional branches,
// producing flush/muxpc recovery controls, training the table and counting
// resolved branches and mispredictions (both saturating at 32'hFFFF_FFFF).
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset; forces all IF/control outputs to 0
//   bus  branch_predictor_bht_if.slave (see interface file for signal list)
// ---------------------------------------------------------------------------
module branch_predictor_bht
  import branch_predictor_bht_pkg::*;
#(
  parameter int IDX_W  = 6,
  parameter int TAG_W  = 8,
  parameter int CNT_W  = 2,
  parameter int ADDR_W = 32
) (
  input logic                   clk,
  input logic                   rst,
  branch_predictor_bht_if.slave bus
);

  logic [IDX_W-1:0]  w_if_idx;
  logic [TAG_W-1:0]  w_if_tag;
  logic [IDX_W-1:0]  w_id_idx;
  logic [TAG_W-1:0]  w_id_tag;

  logic              w_rd_valid;
  logic [TAG_W-1:0]  w_rd_tag;
  logic [ADDR_W-1:0] w_rd_target;
  logic [CNT_W-1:0]  w_rd_counter;

  logic              w_hit;
  logic              w_taken;
  logic              w_resolve;
  logic              w_mispredict;
  logic              w_flush;
  muxpc_e            w_muxpc;

  logic [31:0]       r_branch_count;
  logic [31:0]       r_mispredict_count;

  // Word-aligned PCs: bits [1:0] and anything above the tag are ignored.
  logic              w_unused_pc_bits;
  assign w_unused_pc_bits = ^{bus.if_pc, bus.id_pc};

  assign w_if_idx = bus.if_pc[IDX_W+1:2];
  assign w_if_tag = bus.if_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign w_id_idx = bus.id_pc[IDX_W+1:2];
  assign w_id_tag = bus.id_pc[IDX_W+TAG_W+1:IDX_W+2];

  assign w_resolve    = bus.id_branch && !bus.id_stall;
  assign w_mispredict = w_resolve && (bus.id_pred_taken != bus.id_equal);

  bht_entry_array #(
    .IDX_W  (IDX_W),
    .TAG_W  (TAG_W),
    .CNT_W  (CNT_W),
    .ADDR_W (ADDR_W)
  ) u_entry_array (
    .clk          (clk),
    .rst          (rst),
    .i_rd_idx     (w_if_idx),
    .o_rd_valid   (w_rd_valid),
    .o_rd_tag     (w_rd_tag),
    .o_rd_target  (w_rd_target),
    .o_rd_counter (w_rd_counter),
    .i_wr_en      (w_resolve),
    .i_wr_idx     (w_id_idx),
    .i_wr_tag     (w_id_tag),
    .i_wr_target  (bus.id_target),
    .i_wr_taken   (bus.id_equal)
  );

  // No write bypass: a lookup in the resolving cycle sees the old entry.
  // The rst term keeps outputs quiet even while the table clear settles.
  assign w_hit   = !rst && w_rd_valid && (w_rd_tag == w_if_tag);
  assign w_taken = w_hit && w_rd_counter[CNT_W-1];

  always_comb begin
    w_flush = 1'b0;
    w_muxpc = w_taken ? MUXPC_PRED : MUXPC_SEQ;
    if (rst) begin
      w_muxpc = MUXPC_SEQ;
    end else if (w_mispredict) begin
      w_flush = 1'b1;
      w_muxpc = bus.id_equal ? MUXPC_TARGET : MUXPC_FALLTHRU;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_branch_count     <= '0;
      r_mispredict_count <= '0;
    end else if (w_resolve) begin
      if (r_branch_count != '1) r_branch_count <= r_branch_count + 32'd1;
      if (w_mispredict && (r_mispredict_count != '1))
        r_mispredict_count <= r_mispredict_count + 32'd1;
    end
  end

  assign bus.if_hit           = w_hit;
  assign bus.if_taken         = w_taken;
  assign bus.if_target        = w_hit ? w_rd_target : '0;
  assign bus.flush            = w_flush;
  assign bus.muxpc            = w_muxpc;
  assign bus.branch_count     = r_branch_count;
  assign bus.mispredict_count = r_mispredict_count;

endmodule
